vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_timing_gen_sync_delay_line.sv | 43 ++++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA raster timing generator.
//   - Default 640x480@60 Hz timing (pixel ticks / lines).
//   - Derived totals and inclusive sync windows for the default timing.
//   - COORD_W: width of the DrawX/DrawY coordinate buses.
//   - sync_t: the {hs, vs, blank} bundle carried through the delay line.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_PIX_DIV    = 2;
  localparam int DEF_PIPE_DELAY = 1;

  localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  // Sync windows are inclusive: [START, END].
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Idle level of the delayed outputs: syncs inactive (high), blanked.
  localparam sync_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line
//   Enable-gated shift register, DEPTH stages of WIDTH bits, used to line
//   up hs/vs/blank with the colour pipeline. DEPTH=0 is a plain wire.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (stages -> RESET_VAL)
//   en         : shift enable (one pixel tick)
//   din        : value entering stage 0
//   dout       : value leaving the last stage
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock, reset and enable have no function without storage.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst_n ^ en;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else if (en) begin
          stage_q[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing from the system clock: pixel-tick divider, horizontal
//   and vertical counters, sync/blank decode with a pipeline delay to match
//   the colour mapper, and a once-per-frame pulse plus frame counter.
// Ports:
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   pix_en       : one-Clk pixel-tick strobe
//   DrawX, DrawY : current raster position (undelayed, not clamped)
//   hs, vs       : active-low syncs, delayed PIPE_DELAY ticks
//   blank        : 1 outside the visible area, delayed PIPE_DELAY ticks
//   frame_start  : one-Clk pulse on the tick of the last visible pixel
//   frame_count  : frames completed since reset (wraps)
//
// Strobe semantics: pix_en is a free-running strobe with no back-pressure.
// Every registered raster value (DrawX/DrawY, delay stages, frame_count)
// changes only on the Clk edge that samples pix_en=1, so consumers sample
// on that same edge and see values held for PIX_DIV cycles.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int PIX_DIV    = DEF_PIX_DIV,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic               Clk,
  input  logic               Reset_n,
  output logic               pix_en,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [COORD_W-1:0] X_VIS      = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] Y_VIS      = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] X_LAST_VIS = COORD_W'(H_VISIBLE - 1);
  localparam logic [COORD_W-1:0] Y_LAST_VIS = COORD_W'(V_VISIBLE - 1);

  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_next;
  logic               pix_en_q;
  logic [COORD_W-1:0] hc_q;
  logic [COORD_W-1:0] vc_q;
  logic [15:0]        frame_cnt;
  sync_t              raw;
  sync_t              dly;

  // Divider. pix_en is registered from the next divider value so it is low
  // in reset and high exactly while the divider sits at PIX_DIV-1; with
  // PIX_DIV=1 the divider is stuck at 0 and pix_en stays high after reset.
  assign div_next = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_next;
      pix_en_q <= (div_next == DIV_LAST);
    end
  end

  // Raster counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else if (pix_en_q) begin
      if (hc_q == H_LAST) begin
        hc_q <= '0;
        vc_q <= (vc_q == V_LAST) ? '0 : vc_q + COORD_W'(1);
      end else begin
        hc_q <= hc_q + COORD_W'(1);
      end
    end
  end

  // Raw sync/blank for the pixel currently on DrawX/DrawY.
  always_comb begin
    raw       = SYNC_RESET;
    raw.hs    = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    raw.vs    = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
    raw.blank = (hc_q >= X_VIS) || (vc_q >= Y_VIS);
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_RESET)
  ) u_sync_delay (
    .clk   (Clk),
    .rst_n (Reset_n),
    .en    (pix_en_q),
    .din   (raw),
    .dout  (dly)
  );

  // Frame pulse is decoded from registers; the counter takes it on the same
  // edge that moves the raster off the last visible pixel.
  assign frame_start = pix_en_q && (hc_q == X_LAST_VIS) && (vc_q == Y_LAST_VIS);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign pix_en      = pix_en_q;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = dly.hs;
  assign vs          = dly.vs;
  assign blank       = dly.blank;
  assign frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances: dut_a at full 640x480 timing (PIPE_DELAY=1) for reset and
//   line timing, dut_b on a reduced 24x10 raster (PIPE_DELAY=0) so whole
//   frames, mid-frame reset and frame counter wrap fit in a short run.
//   Expected frame_start events of dut_b go into exp_q; a monitor pops and
//   compares them whenever dut_b raises frame_start.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   cycle   = 0;
  always @(posedge clk) cycle++;

  // ---------------- DUTs ----------------
  logic       pix_en_a, hs_a, vs_a, blank_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [15:0] fc_a;

  logic       pix_en_b, hs_b, vs_b, blank_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [15:0] fc_b;

  vga_timing_gen dut_a (
    .Clk (clk), .Reset_n (rst_a_n), .pix_en (pix_en_a),
    .DrawX (x_a), .DrawY (y_a), .hs (hs_a), .vs (vs_a), .blank (blank_a),
    .frame_start (fs_a), .frame_count (fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .PIX_DIV (2), .PIPE_DELAY (0)
  ) dut_b (
    .Clk (clk), .Reset_n (rst_b_n), .pix_en (pix_en_b),
    .DrawX (x_b), .DrawY (y_b), .hs (hs_b), .vs (vs_b), .blank (blank_b),
    .frame_start (fs_b), .frame_count (fc_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // {DrawX, DrawY, frame_count seen while frame_start is high}
  logic [35:0] exp_q[$];
  int last_fs = -1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  always @(negedge clk) begin
    logic [35:0] e;
    if (rst_b_n && fs_b) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fs_spurious: frame_start at x=%0d y=%0d, none expected", x_b, y_b);
      end else begin
        e = exp_q.pop_front();
        check("fs_x",   32'(x_b),  32'(e[35:26]));
        check("fs_y",   32'(y_b),  32'(e[25:16]));
        check("fs_cnt", 32'(fc_b), 32'(e[15:0]));
      end
      if (last_fs >= 0) check("fs_period_clk", cycle - last_fs, 480);
      last_fs = cycle;
    end
  end

  // ---------------- driver helpers ----------------
  // Advance to the next negedge at which dut_b presents a pixel tick.
  task automatic next_tick_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pix_en_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    bit found;
    int t656, thf, thr, t640, tbr, wraps;
    int vs_low, hs_low, vis;
    logic [9:0] px, py;
    logic ph, pb;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_drawx",   32'(x_a), 0);
    check("rst_drawy",   32'(y_a), 0);
    check("rst_hs",      32'(hs_a), 1);
    check("rst_vs",      32'(vs_a), 1);
    check("rst_blank",   32'(blank_a), 1);
    check("rst_fcount",  32'(fc_a), 0);
    check("rst_pix_en",  32'(pix_en_a), 0);
    check("rst_fstart",  32'(fs_a), 0);
    check("rst_b_fcount", 32'(fc_b), 0);

    // First tick: pix_en high in cycle 2, DrawX 0 -> 1 on its edge
    rst_a_n = 1'b1;
    @(negedge clk);
    check("first_pix_en_hi", 32'(pix_en_a), 1);
    check("first_drawx_0",   32'(x_a), 0);
    @(negedge clk);
    check("first_pix_en_lo", 32'(pix_en_a), 0);
    check("first_drawx_1",   32'(x_a), 1);
    check("first_blank_lo",  32'(blank_a), 0);

    // Line timing on the full raster (PIPE_DELAY=1)
    t656 = -1; thf = -1; thr = -1; t640 = -1; tbr = -1; wraps = 0;
    px = x_a; py = y_a; ph = hs_a; pb = blank_a;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      if (x_a == 10'd656 && t656 < 0) t656 = i;
      if (x_a == 10'd640 && t640 < 0) t640 = i;
      if (ph && !hs_a && thf < 0) thf = i;
      if (!ph && hs_a && thf >= 0 && thr < 0) thr = i;
      if (!pb && blank_a && tbr < 0) tbr = i;
      if (px == 10'd799 && x_a != 10'd799) begin
        wraps++;
        check("a_wrap_x", 32'(x_a), 0);
        check("a_wrap_y", 32'(y_a), 32'(py) + 1);
      end
      px = x_a; py = y_a; ph = hs_a; pb = blank_a;
    end
    check("a_drawx_656_seen", 32'(t656 >= 0), 1);
    check("a_hs_fall_lag_clk", thf - t656, 2);
    check("a_hs_low_clk", thr - thf, 192);
    check("a_blank_rise_lag_clk", tbr - t640, 2);
    check("a_line_wraps", wraps, 1);
    check("a_vs_line0", 32'(vs_a), 1);

    // Two full frames on the reduced raster (PIPE_DELAY=0)
    exp_q.push_back({10'd15, 10'd5, 16'd0});
    exp_q.push_back({10'd15, 10'd5, 16'd1});
    vs_low = 0; hs_low = 0; vis = 0;
    rst_b_n = 1'b1;
    for (int k = 0; k < 480; k++) begin
      next_tick_b(ok);
      if (!ok) begin
        check("b_tick_timeout", 0, 1);
        break;
      end
      if (!vs_b) vs_low++;
      if (!hs_b) hs_low++;
      if (!blank_b) vis++;
      if (k == 0) begin
        check("b_start_x", 32'(x_b), 0);
        check("b_start_y", 32'(y_b), 0);
      end
      if (k == 15) begin
        check("b_x_15", 32'(x_b), 15);
        check("b_blank_at_15", 32'(blank_b), 0);
      end
      if (k == 16) begin
        check("b_x_16", 32'(x_b), 16);
        check("b_blank_at_16", 32'(blank_b), 1);
      end
      if (k == 239) begin
        check("b_max_x", 32'(x_b), 23);
        check("b_max_y", 32'(y_b), 9);
      end
      if (k == 240) begin
        check("b_frame_wrap_x", 32'(x_b), 0);
        check("b_frame_wrap_y", 32'(y_b), 0);
        check("b_fcount_1", 32'(fc_b), 1);
      end
    end
    check("b_vs_low_ticks", vs_low, 96);
    check("b_hs_low_ticks", hs_low, 60);
    check("b_visible_ticks", vis, 192);
    check("b_fcount_2", 32'(fc_b), 2);
    check("b_fs_all_seen", exp_q.size(), 0);

    // Mid-frame reset at (10,3)
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      next_tick_b(ok);
      if (ok && x_b == 10'd10 && y_b == 10'd3) found = 1'b1;
    end
    check("b_reached_10_3", 32'(found), 1);
    rst_b_n = 1'b0;
    last_fs = -1;
    #1;
    check("mid_rst_x", 32'(x_b), 0);
    check("mid_rst_y", 32'(y_b), 0);
    check("mid_rst_fcount", 32'(fc_b), 0);
    check("mid_rst_pix_en", 32'(pix_en_b), 0);
    check("mid_rst_fstart", 32'(fs_b), 0);
    check("mid_rst_hs", 32'(hs_b), 1);
    check("mid_rst_vs", 32'(vs_b), 1);
    @(negedge clk);
    rst_b_n = 1'b1;
    exp_q.push_back({10'd15, 10'd5, 16'd0});
    for (int k = 0; k < 240; k++) begin
      next_tick_b(ok);
      if (!ok) begin
        check("b_restart_timeout", 0, 1);
        break;
      end
      if (k == 0) begin
        check("restart_x", 32'(x_b), 0);
        check("restart_y", 32'(y_b), 0);
      end
    end
    check("restart_fcount_1", 32'(fc_b), 1);
    check("restart_fs_seen", exp_q.size(), 0);

    // Frame counter wrap
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      next_tick_b(ok);
      if (ok && x_b == 10'd0 && y_b == 10'd2) found = 1'b1;
    end
    check("b_reached_line_2", 32'(found), 1);
    force dut_b.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_b.frame_cnt;
    #1;
    check("wrap_preload", 32'(fc_b), 32'hFFFF);
    exp_q.push_back({10'd15, 10'd5, 16'hFFFF});
    for (int k = 0; k < 200; k++) begin
      next_tick_b(ok);
      if (!ok) begin
        check("b_wrap_timeout", 0, 1);
        break;
      end
    end
    check("wrap_fcount_0", 32'(fc_b), 0);
    check("wrap_fs_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
